segre_mem_arbiter: RTL and testbench
====================================

Name: segre_mem_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (IF, read-only) and load/store unit (LSU, read/write).
- Sits between the core's fetch/LSU stages and the memory model.
- Grants one transaction at a time, registers its fields and drives the memory strobes.
- Routes the returned line or write acknowledge back to the owner.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORD_WIDTH, 32, store data width.
- LINE_WIDTH, 128, memory read line width.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  asynchronous active-low reset
- if_rd_i  in  1  IF read request
- if_addr_i  in  ADDR_WIDTH  IF address
- if_line_o  out  LINE_WIDTH  IF returned line
- if_ready_o  out  1  IF completion pulse
- lsu_rd_i  in  1  LSU read request
- lsu_wr_i  in  1  LSU write request
- lsu_addr_i  in  ADDR_WIDTH  LSU address
- lsu_data_i  in  WORD_WIDTH  LSU store data
- lsu_data_type_i  in  2  memop_data_type_e (BYTE/HALF/WORD)
- lsu_line_o  out  LINE_WIDTH  LSU returned line
- lsu_ready_o  out  1  LSU completion pulse
- mem_rd_o  out  1  memory read strobe
- mem_wr_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wr_data_o  out  WORD_WIDTH  memory store data
- mem_data_type_o  out  2  memory access size
- mem_rd_data_i  in  LINE_WIDTH  memory read line
- mem_ready_i  in  1  memory completion, one-cycle pulse

Behaviour:
- Single clock clk_i. Reset rsn_i is asynchronous, active-low.
- Reset values:
  - state IDLE; owner NONE.
  - All strobes and ready pulses 0; all address, data and line outputs 0; data_type WORD.
  - Round-robin pointer favours LSU.
- Requester rule: hold the request and its fields stable until the ready pulse. Drop or change it in the cycle after ready at the earliest.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - Arbitrate among pending requests (see Optional Feature).
  - On a grant, register addr, data, type, op and owner. Next state MEM.
  - No request: stay IDLE.
- MEM:
  - mem_rd_o/mem_wr_o held high with the registered fields every cycle until mem_ready_i.
  - On mem_ready_i: capture mem_rd_data_i into the owner's line register; strobes drop next cycle. Next state RESP.
  - Timeout: none, wait indefinitely.
- RESP:
  - Owner's ready pulses high for exactly one cycle; other ready stays 0.
  - Requests are not sampled. Next state IDLE.
- Latency: request seen in IDLE at cycle N → strobe from N+1 → mem_ready_i at M → requester ready at M+1. Back-to-back grants are spaced ≥3 cycles.
- Line outputs hold their last captured value until that requester's next completion.
- Writes: the owner's line output is not updated; ready still pulses.
- lsu_rd_i and lsu_wr_i both high: treated as write.
- A request arriving while not IDLE waits. A request deasserted before grant is ignored.
- mem_ready_i outside MEM is ignored.
- Reset mid-operation: the in-flight transaction is discarded and all outputs return to reset values. Memory shares rsn_i.

Optional Feature:
- Macro SEGRE_MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - With both requesting, grant the side the pointer favours.
  - After each grant, the pointer flips to the other side.
  - A single requester is always granted.
- Undefined: fixed priority, LSU over IF. The pointer register is not built.

Decomposition:
- segre_pkg holds:
  - memop_data_type_e (BYTE=0, HALF=1, WORD=2)
  - arb_state_e {IDLE, MEM, RESP}
  - arb_owner_e {NONE, IF, LSU}
  - LINE_WIDTH constant
- Sub-module segre_mem_arb_pick: combinational winner selection from the two requests plus the pointer, containing the macro logic.
- FSM and registers live in the top module.

Test Plan:
- IF-only read, addr 0x0000_0100, memory ready after 3 strobe cycles → mem_rd_o high 3 cycles, addr 0x100; if_ready_o pulses one cycle later with the line; lsu_ready_o stays 0.
- LSU write, addr 0x200, data 0xDEADBEEF, type WORD → mem_wr_o high with those fields; lsu_ready_o pulses; lsu_line_o unchanged.
- IF and LSU requesting in the same cycle, both held for two transactions:
  - RR_EN undefined: LSU first, then LSU again if it re-requests, IF starves.
  - RR_EN defined: LSU, then IF.
- lsu_rd_i and lsu_wr_i both high → write issued, mem_rd_o stays 0.
- rsn_i asserted during MEM with mem_rd_o high → outputs zero immediately without a clock; after release, state IDLE and no stale ready pulse.
- Spurious mem_ready_i in IDLE → no ready pulse and no line update.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types for the segre memory arbiter.
// Build option: SEGRE_MEM_ARB_RR_EN selects round-robin arbitration.
package segre_pkg;

  localparam int LINE_WIDTH = 128;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IF   = 2'd1,
    LSU  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/segre_mem_arb_pick.sv
// Winner selection between IF and LSU requests.
// SEGRE_MEM_ARB_RR_EN: pointer-based round robin, else LSU priority.
module segre_mem_arb_pick
  import segre_pkg::*;
(
  input  logic if_req_i,
  input  logic lsu_req_i,
`ifdef SEGRE_MEM_ARB_RR_EN
  input  logic ptr_lsu_i,
`endif
  output logic gnt_if_o,
  output logic gnt_lsu_o
);

  always_comb begin
    gnt_if_o  = 1'b0;
    gnt_lsu_o = 1'b0;
`ifdef SEGRE_MEM_ARB_RR_EN
    if (if_req_i && lsu_req_i) begin
      gnt_lsu_o = ptr_lsu_i;
      gnt_if_o  = !ptr_lsu_i;
    end else begin
      gnt_lsu_o = lsu_req_i;
      gnt_if_o  = if_req_i;
    end
`else
    gnt_lsu_o = lsu_req_i;
    gnt_if_o  = if_req_i && !lsu_req_i;
`endif
  end

endmodule

// File: rtl/segre_mem_arbiter.sv
// Single memory port shared by instruction fetch and the LSU.
// SEGRE_MEM_ARB_RR_EN enables round-robin instead of LSU priority.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = segre_pkg::LINE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  if_rd_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [LINE_WIDTH-1:0] if_line_o,
  output logic                  if_ready_o,
  input  logic                  lsu_rd_i,
  input  logic                  lsu_wr_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [WORD_WIDTH-1:0] lsu_data_i,
  input  logic [1:0]            lsu_data_type_i,
  output logic [LINE_WIDTH-1:0] lsu_line_o,
  output logic                  lsu_ready_o,
  output logic                  mem_rd_o,
  output logic                  mem_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WORD_WIDTH-1:0] mem_wr_data_o,
  output logic [1:0]            mem_data_type_o,
  input  logic [LINE_WIDTH-1:0] mem_rd_data_i,
  input  logic                  mem_ready_i
);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  memop_data_type_e      type_q, type_d;
  logic                  wr_q, wr_d;
  logic [LINE_WIDTH-1:0] if_line_q, if_line_d;
  logic [LINE_WIDTH-1:0] lsu_line_q, lsu_line_d;
  logic                  gnt_if, gnt_lsu;
  logic                  lsu_req;

  assign lsu_req = lsu_rd_i || lsu_wr_i;

`ifdef SEGRE_MEM_ARB_RR_EN
  logic ptr_q, ptr_d;
`endif

  segre_mem_arb_pick u_pick (
    .if_req_i  (if_rd_i),
    .lsu_req_i (lsu_req),
`ifdef SEGRE_MEM_ARB_RR_EN
    .ptr_lsu_i (ptr_q),
`endif
    .gnt_if_o  (gnt_if),
    .gnt_lsu_o (gnt_lsu)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    data_d     = data_q;
    type_d     = type_q;
    wr_d       = wr_q;
    if_line_d  = if_line_q;
    lsu_line_d = lsu_line_q;
`ifdef SEGRE_MEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_lsu) begin
          state_d = MEM;
          owner_d = LSU;
          addr_d  = lsu_addr_i;
          data_d  = lsu_data_i;
          type_d  = memop_data_type_e'(lsu_data_type_i);
          // rd and wr together resolve to a write
          wr_d    = lsu_wr_i;
`ifdef SEGRE_MEM_ARB_RR_EN
          ptr_d   = 1'b0;
`endif
        end else if (gnt_if) begin
          state_d = MEM;
          owner_d = IF;
          addr_d  = if_addr_i;
          data_d  = '0;
          type_d  = WORD;
          wr_d    = 1'b0;
`ifdef SEGRE_MEM_ARB_RR_EN
          ptr_d   = 1'b1;
`endif
        end
      end
      MEM: begin
        if (mem_ready_i) begin
          state_d = RESP;
          if (!wr_q && owner_q == LSU) lsu_line_d = mem_rd_data_i;
          if (!wr_q && owner_q == IF)  if_line_d  = mem_rd_data_i;
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= IDLE;
      owner_q    <= NONE;
      addr_q     <= '0;
      data_q     <= '0;
      type_q     <= WORD;
      wr_q       <= 1'b0;
      if_line_q  <= '0;
      lsu_line_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      type_q     <= type_d;
      wr_q       <= wr_d;
      if_line_q  <= if_line_d;
      lsu_line_q <= lsu_line_d;
    end
  end

`ifdef SEGRE_MEM_ARB_RR_EN
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end
`endif

  assign mem_rd_o        = (state_q == MEM) && !wr_q;
  assign mem_wr_o        = (state_q == MEM) && wr_q;
  assign mem_addr_o      = addr_q;
  assign mem_wr_data_o   = data_q;
  assign mem_data_type_o = type_q;
  assign if_line_o       = if_line_q;
  assign lsu_line_o      = lsu_line_q;
  assign if_ready_o      = (state_q == RESP) && (owner_q == IF);
  assign lsu_ready_o     = (state_q == RESP) && (owner_q == LSU);

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench for segre_mem_arbiter with a latency-programmable memory.
// Expected grant order follows SEGRE_MEM_ARB_RR_EN when defined.
module tb_segre_mem_arbiter;

  logic         clk_i = 1'b0;
  logic         rsn_i;
  logic         if_rd_i;
  logic [31:0]  if_addr_i;
  logic [127:0] if_line_o;
  logic         if_ready_o;
  logic         lsu_rd_i;
  logic         lsu_wr_i;
  logic [31:0]  lsu_addr_i;
  logic [31:0]  lsu_data_i;
  logic [1:0]   lsu_data_type_i;
  logic [127:0] lsu_line_o;
  logic         lsu_ready_o;
  logic         mem_rd_o;
  logic         mem_wr_o;
  logic [31:0]  mem_addr_o;
  logic [31:0]  mem_wr_data_o;
  logic [1:0]   mem_data_type_o;
  logic [127:0] mem_rd_data_i;
  logic         mem_ready_i;

  segre_mem_arbiter dut (
    .clk_i           (clk_i),
    .rsn_i           (rsn_i),
    .if_rd_i         (if_rd_i),
    .if_addr_i       (if_addr_i),
    .if_line_o       (if_line_o),
    .if_ready_o      (if_ready_o),
    .lsu_rd_i        (lsu_rd_i),
    .lsu_wr_i        (lsu_wr_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_type_i (lsu_data_type_i),
    .lsu_line_o      (lsu_line_o),
    .lsu_ready_o     (lsu_ready_o),
    .mem_rd_o        (mem_rd_o),
    .mem_wr_o        (mem_wr_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wr_data_o   (mem_wr_data_o),
    .mem_data_type_o (mem_data_type_o),
    .mem_rd_data_i   (mem_rd_data_i),
    .mem_ready_i     (mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          lsu;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  typ;
  } mem_exp_t;

  typedef struct {
    bit           lsu;
    logic [127:0] if_line;
    logic [127:0] lsu_line;
  } rsp_exp_t;

  mem_exp_t     mem_q[$];
  rsp_exp_t     rsp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           lat = 3;
  int           cnt = 0;
  int           rdy_cyc = -10;
  int           spur_req = 0;
  int           spur_done = 0;
  bit           prev_rdy = 0;
  logic [127:0] exp_if_line = '0;
  logic [127:0] exp_lsu_line = '0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a ^ 32'h1111_1111, a ^ 32'h2222_2222, ~a, a};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: answers after lat strobe cycles, checks issued fields
  always @(negedge clk_i) begin
    if (!rsn_i) begin
      cnt = 0;
      mem_ready_i = 1'b0;
    end else if (mem_ready_i) begin
      mem_ready_i = 1'b0;
      chk("strobe_drop", {mem_rd_o, mem_wr_o}, 2'b00);
    end else if (spur_req != spur_done) begin
      spur_done = spur_req;
      mem_rd_data_i = {4{32'hFFFF_0000}};
      mem_ready_i = 1'b1;
    end else if (mem_rd_o || mem_wr_o) begin
      cnt++;
      if (cnt >= lat) begin
        cnt = 0;
        if (mem_q.size() == 0) begin
          fail("unexpected_mem_op");
        end else begin
          mem_exp_t e;
          e = mem_q.pop_front();
          chk("mem_rd", mem_rd_o, e.rd);
          chk("mem_wr", mem_wr_o, e.wr);
          chk("mem_addr", mem_addr_o, e.addr);
          if (e.wr) chk("mem_wr_data", mem_wr_data_o, e.data);
          if (e.lsu) chk("mem_type", mem_data_type_o, e.typ);
        end
        mem_rd_data_i = mem_wr_o ? line_of(~mem_addr_o)
                                 : line_of(mem_addr_o);
        mem_ready_i = 1'b1;
        rdy_cyc = cyc;
      end
    end
  end

  // Response monitor
  always @(negedge clk_i) begin
    if (!rsn_i) begin
      prev_rdy = 1'b0;
    end else begin
      if (if_ready_o || lsu_ready_o) begin
        if (prev_rdy) fail("ready_pulse_width");
        if (rsp_q.size() == 0) begin
          fail("unexpected_ready");
        end else begin
          rsp_exp_t r;
          r = rsp_q.pop_front();
          chk("rsp_owner", {if_ready_o, lsu_ready_o},
              r.lsu ? 2'b01 : 2'b10);
          chk("rsp_if_line", if_line_o, r.if_line);
          chk("rsp_lsu_line", lsu_line_o, r.lsu_line);
          chk("rsp_latency", cyc, rdy_cyc + 1);
        end
      end
      prev_rdy = if_ready_o || lsu_ready_o;
    end
  end

  task automatic expect_op(input bit lsu, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] t);
    mem_q.push_back('{rd, wr, lsu, a, d, t});
    if (rd && lsu)  exp_lsu_line = line_of(a);
    if (rd && !lsu) exp_if_line  = line_of(a);
    rsp_q.push_back('{lsu, exp_if_line, exp_lsu_line});
  endtask

  task automatic wait_ready(output bit who_lsu);
    int n = 0;
    who_lsu = 1'b0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!(if_ready_o || lsu_ready_o) && n < 60);
    if (!(if_ready_o || lsu_ready_o)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready, expected one");
    end else begin
      who_lsu = lsu_ready_o;
    end
  endtask

  task automatic run_op(input bit lsu, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] t, input int l);
    bit w;
    lat = l;
    expect_op(lsu, rd && !wr, wr, a, d, t);
    @(posedge clk_i);
    #1;
    if (lsu) begin
      lsu_rd_i = rd;
      lsu_wr_i = wr;
      lsu_addr_i = a;
      lsu_data_i = d;
      lsu_data_type_i = t;
    end else begin
      if_rd_i = 1'b1;
      if_addr_i = a;
    end
    wait_ready(w);
    @(posedge clk_i);
    #1;
    if_rd_i = 1'b0;
    lsu_rd_i = 1'b0;
    lsu_wr_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit w;
    int lsu_n;
    rsn_i = 1'b0;
    if_rd_i = 1'b0;
    if_addr_i = '0;
    lsu_rd_i = 1'b0;
    lsu_wr_i = 1'b0;
    lsu_addr_i = '0;
    lsu_data_i = '0;
    lsu_data_type_i = 2'd2;
    mem_rd_data_i = '0;
    mem_ready_i = 1'b0;

    @(negedge clk_i);
    chk("rst_strobes", {mem_rd_o, mem_wr_o}, 2'b00);
    chk("rst_ready", {if_ready_o, lsu_ready_o}, 2'b00);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wr_data_o, 32'h0);
    chk("rst_type", mem_data_type_o, 2'd2);
    chk("rst_lines", {if_line_o, lsu_line_o}, 256'h0);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;

    run_op(0, 1, 0, 32'h0000_0100, 32'h0, 2'd2, 3);
    run_op(1, 0, 1, 32'h0000_0200, 32'hDEAD_BEEF, 2'd2, 2);
    run_op(1, 1, 0, 32'h0000_0240, 32'h0, 2'd1, 1);
    run_op(1, 1, 1, 32'h0000_0280, 32'h1234_5678, 2'd0, 2);
    run_op(0, 1, 0, 32'h0000_0104, 32'h0, 2'd2, 1);

    lat = 2;
`ifdef SEGRE_MEM_ARB_RR_EN
    expect_op(1, 1, 0, 32'h400, 32'h0, 2'd2);
    expect_op(0, 1, 0, 32'h300, 32'h0, 2'd2);
    expect_op(1, 1, 0, 32'h410, 32'h0, 2'd2);
`else
    expect_op(1, 1, 0, 32'h400, 32'h0, 2'd2);
    expect_op(1, 1, 0, 32'h410, 32'h0, 2'd2);
    expect_op(0, 1, 0, 32'h300, 32'h0, 2'd2);
`endif
    @(posedge clk_i);
    #1;
    lsu_n = 0;
    if_rd_i = 1'b1;
    if_addr_i = 32'h300;
    lsu_rd_i = 1'b1;
    lsu_addr_i = 32'h400;
    lsu_data_type_i = 2'd2;
    repeat (3) begin
      wait_ready(w);
      @(posedge clk_i);
      #1;
      if (w && lsu_n == 0) begin
        lsu_addr_i = 32'h410;
        lsu_n = 1;
      end else if (w) begin
        lsu_rd_i = 1'b0;
      end else begin
        if_rd_i = 1'b0;
      end
    end
    chk("fair_drained", rsp_q.size(), 0);

    spur_req++;
    repeat (4) @(negedge clk_i);
    chk("spur_if_line", if_line_o, exp_if_line);
    chk("spur_lsu_line", lsu_line_o, exp_lsu_line);
    chk("spur_strobes", {mem_rd_o, mem_wr_o}, 2'b00);

    lat = 10;
    expect_op(0, 1, 0, 32'h500, 32'h0, 2'd2);
    @(posedge clk_i);
    #1;
    if_rd_i = 1'b1;
    if_addr_i = 32'h500;
    for (int i = 0; i < 20 && !mem_rd_o; i++) @(negedge clk_i);
    chk("pre_rst_strobe", mem_rd_o, 1'b1);
    #2;
    rsn_i = 1'b0;
    #1;
    chk("mid_rst_strobes", {mem_rd_o, mem_wr_o}, 2'b00);
    chk("mid_rst_addr", mem_addr_o, 32'h0);
    chk("mid_rst_type", mem_data_type_o, 2'd2);
    chk("mid_rst_lines", {if_line_o, lsu_line_o}, 256'h0);
    chk("mid_rst_ready", {if_ready_o, lsu_ready_o}, 2'b00);
    mem_q.delete();
    rsp_q.delete();
    exp_if_line = '0;
    exp_lsu_line = '0;
    if_rd_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("post_rst_strobes", {mem_rd_o, mem_wr_o}, 2'b00);

    run_op(0, 1, 0, 32'h0000_0600, 32'h0, 2'd2, 2);
    run_op(1, 1, 0, 32'h0000_0640, 32'h0, 2'd2, 1);
    repeat (3) @(negedge clk_i);
    chk("end_drained", mem_q.size() + rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
